uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart` transmitter between up to NREQ byte producers. It sits between the producers and the uart's `uart_wr_i`/`uart_dat_i`/`uart_busy` pins. It latches the winning byte and drives the write strobe for a fixed hold time. It then tracks `uart_busy` through the frame and returns a one-cycle acknowledge to the owner when the frame has finished.

---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between NREQ byte producers using a
// round-robin policy. The winning byte is latched at grant time, the write
// strobe is held for WR_HOLD cycles, the UART busy flag is tracked through
// the frame, and the owner receives a one-cycle acknowledge when the frame
// has completed.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in WAIT_BUSY / WAIT_DONE.
//   Reaching TIMEOUT cycles forces the ACK state and sets the sticky err_o.
//   When undefined, the FSM waits indefinitely and err_o is constant 0.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   WR_HOLD  cycles uart_wr_o stays high per transfer (>= 1)
//   TIMEOUT  watchdog limit in cycles (watchdog builds only)
//
// Ports:
//   sys_clk_i    in   1       system clock
//   sys_rst_i    in   1       asynchronous active-high reset
//   req_i        in   NREQ    bit i high: requester i has a byte pending
//   req_dat_i    in   8*NREQ  byte of requester i on bits [8i+7:8i]
//   grant_o      out  NREQ    one-hot current owner, 0 when idle
//   ack_o        out  NREQ    one-cycle pulse when owner's transfer completes
//   uart_wr_o    out  1       write strobe to the UART
//   uart_dat_o   out  8       byte to the UART
//   uart_busy_i  in   1       UART busy flag
//   err_o        out  1       sticky watchdog error
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int WR_HOLD = 10,
  parameter int TIMEOUT = 8192
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_dat_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   ack_o,
  output logic              uart_wr_o,
  output logic [7:0]        uart_dat_o,
  input  logic              uart_busy_i,
  output logic              err_o
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(WR_HOLD + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  logic [2:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ack;
  logic            r_wr;
  logic [7:0]      r_dat;
  logic [HW-1:0]   r_hold_cnt;

  logic [7:0]      w_bytes [NREQ];
  logic            w_found;
  logic [PW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_onehot;
  logic [PW-1:0]   w_ptr_next;

  // Unpack the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign w_bytes[gi] = req_dat_i[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_i[idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_onehot        = '0;
    w_sel_onehot[w_sel] = 1'b1;
  end

  assign w_ptr_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd_cnt;
  logic           r_err;
  logic           w_wd_expired;
  assign w_wd_expired = (r_wd_cnt == WDW'(TIMEOUT - 1));
  assign err_o        = r_err;
`else
  // TIMEOUT only matters for watchdog builds; this expression is constant 0.
  assign err_o = (TIMEOUT < 0);
`endif

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_wr       <= 1'b0;
      r_dat      <= '0;
      r_hold_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_wd_cnt   <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !uart_busy_i) begin
            r_grant    <= w_sel_onehot;
            r_owner    <= w_sel;
            r_dat      <= w_bytes[w_sel];
            r_wr       <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The strobe already went high on the grant edge, so it drops
          // once WR_HOLD-1 further cycles have been counted.
          if (r_hold_cnt == HW'(WR_HOLD - 1)) begin
            r_wr    <= 1'b0;
            r_state <= ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_ACK;
          end else if (uart_busy_i) begin
            r_wd_cnt <= '0;
            r_state  <= ST_WAIT_DONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`else
          if (uart_busy_i) r_state <= ST_WAIT_DONE;
`endif
        end
        ST_WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_ACK;
          end else if (!uart_busy_i) begin
            r_state <= ST_ACK;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`else
          if (!uart_busy_i) r_state <= ST_ACK;
`endif
        end
        ST_ACK: begin
          r_ack   <= r_grant;
          r_grant <= '0;
          r_dat   <= '0;
          r_wr    <= 1'b0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o    = r_grant;
  assign ack_o      = r_ack;
  assign uart_wr_o  = r_wr;
  assign uart_dat_o = r_dat;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Randomized self-checking bench for uart_tx_arbiter (NREQ=4, WR_HOLD=10).
// The bench plays the UART itself by driving uart_busy_i, and keeps a
// behavioural model of the pending-request set, the round-robin pointer and
// the sticky error to predict every grant, byte and acknowledge.
// Watchdog builds (UART_ARB_TIMEOUT_EN) use TIMEOUT=100.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int WR_HOLD = 10;
  localparam int TB_TO   = 100;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] req_dat_i;
  logic [NREQ-1:0]   grant_o;
  logic [NREQ-1:0]   ack_o;
  logic              uart_wr_o;
  logic [7:0]        uart_dat_o;
  logic              uart_busy_i;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [NREQ-1:0] m_req;
  logic [7:0]      m_dat [NREQ];
  int              m_ptr;
  logic            m_err;

  uart_tx_arbiter #(.NREQ(NREQ), .WR_HOLD(WR_HOLD), .TIMEOUT(TB_TO)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .req_i       (req_i),
    .req_dat_i   (req_dat_i),
    .grant_o     (grant_o),
    .ack_o       (ack_o),
    .uart_wr_o   (uart_wr_o),
    .uart_dat_o  (uart_dat_o),
    .uart_busy_i (uart_busy_i),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) chk("onehot", {30'd0, $onehot0(grant_o), $onehot0(ack_o)}, 32'd3);
  end

  task automatic drive_inputs();
    req_i = m_req;
    for (int i = 0; i < NREQ; i++) req_dat_i[8*i +: 8] = m_dat[i];
  endtask

  // One complete transfer. Called #1 after an edge with m_req nonzero.
  task automatic xfer(input bit drop, input int pre_busy, input int stuck);
    int owner;
    int n_wr;
    int guard;
    int acks;
    int d;
    int len;
    logic [7:0] exp_byte;
    logic [NREQ-1:0] exp_oh;

    owner = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (owner < 0 && m_req[(m_ptr + k) % NREQ]) owner = (m_ptr + k) % NREQ;
    end
    if (owner < 0) owner = 0;
    exp_oh   = NREQ'(1) << owner;
    exp_byte = m_dat[owner];
    drive_inputs();

    if (pre_busy > 0) begin
      uart_busy_i = 1'b1;
      repeat (pre_busy) begin
        @(posedge clk); #1;
        chk("busy_nogrant", grant_o, 0);
      end
      uart_busy_i = 1'b0;
    end

    @(posedge clk); #1;
    chk("grant", grant_o, exp_oh);
    chk("dat", uart_dat_o, exp_byte);
    chk("wr_rise", uart_wr_o, 1);
    chk("ack_idle", ack_o, 0);

    // Captured data must not follow the requester after grant.
    if (drop) m_req[owner] = 1'b0;
    m_dat[owner] = 8'($urandom);
    drive_inputs();

    n_wr  = 1;
    guard = 0;
    while (uart_wr_o && guard < 100) begin
      @(posedge clk); #1;
      if (uart_wr_o) n_wr++;
      guard++;
    end
    chk("wr_hold", n_wr, WR_HOLD);
    chk("dat_hold", uart_dat_o, exp_byte);

    if (stuck > 0) begin
`ifdef UART_ARB_TIMEOUT_EN
      repeat (TB_TO) @(posedge clk);
      #1;
      chk("wd_pre_ack", ack_o, 0);
      chk("wd_grant", grant_o, exp_oh);
      @(posedge clk); #1;
      chk("wd_ack", ack_o, exp_oh);
      chk("wd_err", err_o, 1);
      chk("wd_wr", uart_wr_o, 0);
      m_err = 1'b1;
      m_ptr = (owner + 1) % NREQ;
      $display("xfer owner=%0d byte=%02h watchdog ack err=%0b", owner, exp_byte, err_o);
      return;
`else
      acks = 0;
      repeat (stuck) begin
        @(posedge clk); #1;
        if (ack_o != 0) acks++;
      end
      chk("stuck_noack", acks, 0);
      chk("stuck_grant", grant_o, exp_oh);
      chk("stuck_err", err_o, 0);
`endif
    end

    // UART stand-in: busy rises after d cycles, stays for len cycles.
    d = int'($urandom_range(0, 3));
    repeat (d) begin @(posedge clk); #1; end
    uart_busy_i = 1'b1;
    len = int'($urandom_range(1, 12));
    repeat (len) begin @(posedge clk); #1; end
    uart_busy_i = 1'b0;

    @(posedge clk); #1;          // edge that samples busy low
    chk("ack_early", ack_o, 0);
    chk("grant_busy", grant_o, exp_oh);
    @(posedge clk); #1;          // ack edge
    chk("ack", ack_o, exp_oh);
    chk("grant_clr", grant_o, 0);
    chk("dat_clr", uart_dat_o, 0);
    chk("err", err_o, 32'(m_err));
    m_ptr = (owner + 1) % NREQ;
    $display("xfer owner=%0d byte=%02h ack=%b", owner, exp_byte, ack_o);
  endtask

  initial begin
    rst         = 1'b1;
    req_i       = '0;
    req_dat_i   = '0;
    uart_busy_i = 1'b0;
    m_req       = '0;
    m_ptr       = 0;
    m_err       = 1'b0;
    for (int i = 0; i < NREQ; i++) m_dat[i] = 8'h00;

    repeat (10) @(posedge clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_wr", uart_wr_o, 0);
    chk("rst_dat", uart_dat_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;

    // All four at once, each dropping after its own service.
    m_req = 4'b1111;
    m_dat[0] = 8'h11; m_dat[1] = 8'h22; m_dat[2] = 8'h33; m_dat[3] = 8'h44;
    for (int n = 0; n < 4; n++) xfer(1'b1, 0, 0);

    // Fairness: 0 and 2 held continuously.
    m_req = 4'b0101;
    m_dat[0] = 8'd30; m_dat[2] = 8'd170;
    for (int n = 0; n < 4; n++) xfer(n == 3, 0, 0);
    m_req = 4'b0100 & m_req;
    if (m_req != 0) xfer(1'b1, 0, 0);

    // UART busy before the request arrives.
    m_req = 4'b0010;
    m_dat[1] = 8'h5A;
    xfer(1'b1, 5, 0);

    // Single request, byte 0x1B.
    m_req = 4'b0001;
    m_dat[0] = 8'h1B;
    xfer(1'b1, 0, 0);

    // UART never raises busy.
    m_req = 4'b1000;
    m_dat[3] = 8'hC3;
`ifdef UART_ARB_TIMEOUT_EN
    xfer(1'b1, 0, 1);
`else
    xfer(1'b1, 0, 20000);
`endif

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      if (m_req == 0) m_req = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) m_dat[i] = 8'($urandom);
      xfer(1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
    end
    m_req = '0;
    drive_inputs();

    // Reset in the middle of a transfer.
    @(posedge clk); #1;
    m_req = 4'b0100;
    m_dat[2] = 8'hA5;
    drive_inputs();
    @(posedge clk); #1;
    chk("pre_rst_grant", grant_o, 4'b0100);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_grant", grant_o, 0);
    chk("midrst_ack", ack_o, 0);
    chk("midrst_wr", uart_wr_o, 0);
    chk("midrst_dat", uart_dat_o, 0);
    chk("midrst_err", err_o, 0);
    m_req = '0;
    drive_inputs();
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("postrst_ack", ack_o, 0);
      chk("postrst_grant", grant_o, 0);
    end
    $display("reset mid-frame: outputs cleared, no ack");

    m_req = 4'b1111;
    for (int i = 0; i < NREQ; i++) m_dat[i] = 8'($urandom);
    xfer(1'b1, 0, 0);
    m_req = '0;
    drive_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
